// File: rtl/sha256_round_controller.sv
// sha256_round_controller: block handshake and 64-round sequencing for the SHA-256 compression datapath
module sha256_round_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic [511:0] sched_data,
  output logic         sched_init,
  output logic         h_load_iv,
  output logic         wv_load,
  output logic         round_en,
  output logic [5:0]   round_index,
  output logic         hash_update,
  output logic         digest_valid,
  output logic         busy,
  output logic [15:0]  block_count,
  output logic         err_no_first
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic first_q, last_q, msg_active;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      msg_active   <= 1'b0;
      sched_data   <= '0;
      block_count  <= '0;
      err_no_first <= 1'b0;
    end else begin
      case (state)
        IDLE: if (blk_valid) begin
          sched_data   <= blk_data;
          first_q      <= blk_first | ~msg_active;
          last_q       <= blk_last;
          msg_active   <= 1'b1;
          err_no_first <= blk_first ? 1'b0 : (msg_active ? err_no_first : 1'b1);
          state        <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          cnt   <= cnt + 6'd1;
          state <= (cnt == 6'd63) ? FINAL : ROUND;
        end
        FINAL: begin
          block_count <= first_q ? 16'd1 : ((block_count == 16'hFFFF) ? block_count : block_count + 16'd1);
          msg_active  <= last_q ? 1'b0 : msg_active;
          state       <= last_q ? DONE : IDLE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign blk_ready    = (state == IDLE) && reset;
  assign sched_init   = state == LOAD;
  assign wv_load      = state == LOAD;
  assign h_load_iv    = (state == LOAD) && first_q;
  assign round_en     = state == ROUND;
  assign round_index  = round_en ? cnt : 6'd0;
  assign hash_update  = state == FINAL;
  assign digest_valid = state == DONE;
  assign busy         = state != IDLE;
endmodule

// File: tb/tb_sha256_round_controller.sv
// tb_sha256_round_controller: randomized timeline-model check of the SHA-256 round controller
module tb_sha256_round_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic blk_valid = 1'b0;
  logic blk_first = 1'b0;
  logic blk_last = 1'b0;
  logic [511:0] blk_data = '0;
  logic blk_ready, sched_init, h_load_iv, wv_load, round_en, hash_update, digest_valid, busy, err_no_first;
  logic [511:0] sched_data;
  logic [5:0] round_index;
  logic [15:0] block_count;
  int checks = 0;
  int failures = 0;
  bit act = 0;
  bit m_first = 0;
  bit m_last = 0;
  bit m_msg = 0;
  bit m_err = 0;
  bit did_mid_reset = 0;
  int k = 0;
  int m_bcount = 0;
  int accepts = 0;
  int digests = 0;
  logic [511:0] m_data = '0;
  sha256_round_controller dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .sched_data(sched_data), .sched_init(sched_init), .h_load_iv(h_load_iv),
    .wv_load(wv_load), .round_en(round_en), .round_index(round_index),
    .hash_update(hash_update), .digest_valid(digest_valid), .busy(busy),
    .block_count(block_count), .err_no_first(err_no_first)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      check("blk_ready", blk_ready, !act && reset);
      check("busy", busy, act);
      check("sched_init", sched_init, act && k == 1);
      check("wv_load", wv_load, act && k == 1);
      check("h_load_iv", h_load_iv, act && k == 1 && m_first);
      check("round_en", round_en, act && k >= 2 && k <= 65);
      check("round_index", round_index, (act && k >= 2 && k <= 65) ? k - 2 : 0);
      check("hash_update", hash_update, act && k == 66);
      check("digest_valid", digest_valid, act && k == 67);
      check("sched_data", sched_data, m_data);
      check("block_count", block_count, m_bcount);
      check("err_no_first", err_no_first, m_err);
      if (c < 3) reset = 1'b0;
      else if (act && k == 32 && !did_mid_reset) begin
        reset = 1'b0;
        did_mid_reset = 1;
      end else reset = ($urandom_range(0, 499) != 0);
      blk_valid = ($urandom_range(0, 3) != 0);
      blk_first = ($urandom_range(0, 3) == 0);
      blk_last = ($urandom_range(0, 2) == 0);
      for (int w = 0; w < 16; w++) blk_data[w*32 +: 32] = $urandom;
      if (!reset) begin
        act = 0; k = 0; m_first = 0; m_last = 0; m_msg = 0; m_err = 0; m_bcount = 0; m_data = '0;
      end else if (act) begin
        if (k == 66) begin
          m_bcount = m_first ? 1 : (m_bcount == 65535 ? 65535 : m_bcount + 1);
          if (m_last) m_msg = 0;
        end
        if (k == 67) digests++;
        k++;
        if (k == (m_last ? 68 : 67)) begin
          act = 0;
          k = 0;
        end
      end else if (blk_valid) begin
        accepts++;
        act = 1;
        k = 1;
        m_data = blk_data;
        m_first = blk_first || !m_msg;
        m_last = blk_last;
        if (blk_first) m_err = 0;
        else if (!m_msg) m_err = 1;
        m_msg = 1;
      end
    end
    check("mid_round_reset_exercised", did_mid_reset, 1'b1);
    check("traffic_seen", (accepts > 20 && digests > 5), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
